uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (7 data bits, parity, 10 MHz clock, 521 clocks/bit) between NUM_REQ requesters.
- Picks a winner round-robin, latches its 7-bit word and drives a one-cycle tx_start with a stable datain_tx.
- The UART has no busy output, so this block times the full frame plus an inter-frame gap before accepting the next request.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 7, payload width, matches UART datain_tx
- CLKS_PER_BIT, 521, clock cycles per UART bit
- FRAME_BITS, 10, bits per frame: start + 7 data + parity + stop
- GAP_BITS, 1, idle bit-times inserted after each frame
- Localparam IDW = clog2(NUM_REQ), min 1
- Localparam FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS
- Localparam GAP_CLKS = CLKS_PER_BIT*GAP_BITS

Ports:
- clk  in  1  system clock, 10 MHz, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester send request, level, held until gnt
- data_in  in  NUM_REQ*DATA_W  flattened words; requester i at [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: word of requester i accepted
- grant_id  out  IDW  index of last granted requester
- tx_start  out  1  to UART tx_start, one-cycle pulse
- datain_tx  out  DATA_W  to UART datain_tx, stable from tx_start through end of GAP
- busy  out  1  high from grant cycle until return to IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Every output is registered.
- Reset values: gnt=0, grant_id=0, tx_start=0, datain_tx=0, busy=0, state=IDLE, counter=0, rr_ptr=0.
- States:
  - IDLE: if req != 0 at a rising edge, that edge does the following:
    - sets gnt[w]=1, tx_start=1, busy=1 and grant_id=w;
    - latches datain_tx=data_in[w];
    - loads counter with FRAME_CLKS-1;
    - moves state to SEND.
  - SEND: gnt and tx_start return to 0 on the next cycle. Counter decrements each cycle. At counter==0, load GAP_CLKS-1 and go to GAP.
  - GAP: decrement the counter. At counter==0, set busy=0 and go to IDLE. If GAP_BITS==0, SEND goes directly to IDLE.
- Latency:
  - req high in IDLE gives gnt/tx_start on the next edge (1 cycle).
  - busy stays high for exactly FRAME_CLKS+GAP_CLKS cycles, 5731 with the defaults.
  - The next grant can come on the first IDLE cycle.
- Arbitration (round-robin):
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first asserted req wins.
  - After a grant to w, rr_ptr = (w+1) mod NUM_REQ.
  - Wrap-around: with NUM_REQ=4 and w=3, rr_ptr becomes 0.
- Requests arriving while busy are ignored (not queued). They stay pending as long as req is held.
- A req deasserted before its gnt is a withdrawal: no grant and no side effects.
- data_in is sampled only on the grant edge. Later changes do not affect datain_tx.
- Simultaneous requests: exactly one gnt bit is high per grant. The others wait for later arbitration rounds.
- gnt is never asserted while busy was high in the previous cycle.
- Reset mid-frame: all outputs go to reset values immediately. The UART frame in flight is truncated (UART behaviour undefined). After release, arbitration restarts at rr_ptr=0.
- If req is held continuously by all requesters, grants rotate 0,1,2,3,0,… with no starvation.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined:
  - Requester 0 is high priority: if req[0] is high in IDLE it always wins, regardless of rr_ptr.
  - rr_ptr is not updated on a requester-0 grant.
  - The other requesters arbitrate round-robin among themselves.
- Undefined: pure round-robin over all requesters, requester 0 not special.

Test Plan:
- Single request: reset, release; req=4'b0100, data_in[2]=7'b101_1011 → next edge gnt=4'b0100, tx_start=1 for 1 cycle, datain_tx=7'b101_1011, grant_id=2, busy high 5731 cycles.
- Simultaneous requests: req=4'b1111 held, words 7'h11/7'h22/7'h33/7'h44 → grants in order 0,1,2,3,0. Grant-to-grant spacing is 5732 cycles. datain_tx matches each winner's word.
- Request during busy: req[1] raised at cycle 100 of a frame granted to 0 → no gnt until busy falls. gnt[1] on the first IDLE cycle.
- Withdrawal and data stability: req[3] pulsed for 50 cycles mid-frame → no gnt[3] ever. Changing data_in[0] after its grant leaves datain_tx unchanged.
- Reset mid-frame: rst_n low at cycle 2000 of SEND → all outputs 0 immediately. After release, req=4'b1010 grants requester 1 first (rr_ptr=0).
- With UART_TX_ARB_PRIO0_EN: req=4'b1111 held → requester 0 wins every grant. Drop req[0] → grants to 1,2,3 round-robin.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request/grant and UART-side bundle for uart_tx_arbiter.
// Ports: req/data_in (requesters -> arbiter), gnt/grant_id/busy (arbiter -> requesters),
//        tx_start/datain_tx (arbiter -> UART transmitter).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 7
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [IDW-1:0]            grant_id;
  logic                      tx_start;
  logic [DATA_W-1:0]         datain_tx;
  logic                      busy;

  // Requester side.
  modport master (
    output req, data_in,
    input  gnt, grant_id, tx_start, datain_tx, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data_in,
    output gnt, grant_id, tx_start, datain_tx, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter that has no busy output.
// Ports: clk, rst_n (async, active low), bus (uart_tx_arbiter_if.slave).
// Grant one edge after req in IDLE; busy for FRAME_CLKS+GAP_CLKS cycles, requests ignored meanwhile.
// Optional macro UART_TX_ARB_PRIO0_EN: requester 0 always wins and does not move rr_ptr.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 521,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
  localparam int GAP_CLKS   = CLKS_PER_BIT * GAP_BITS;
  localparam int CNT_MAX    = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDW-1:0]      rr_ptr, rr_n;
  logic [NUM_REQ-1:0]  gnt_q, gnt_n;
  logic [IDW-1:0]      id_q, id_n;
  logic                start_q, start_n;
  logic [DATA_W-1:0]   dat_q, dat_n;
  logic                busy_q, busy_n;

  // Arbitration signals.
  logic [NUM_REQ-1:0]  req_m;
  logic [IDW:0]        idx_sum;
  logic [IDW-1:0]      cand;
  logic                win_vld;
  logic [IDW-1:0]      win_id;
  logic [IDW-1:0]      rr_adv;

  // Round-robin search from rr_ptr. Offsets are scanned from farthest to
  // nearest so the nearest asserted request overwrites the others and wins.
  always_comb begin
    req_m   = bus.req;
`ifdef UART_TX_ARB_PRIO0_EN
    req_m[0] = 1'b0;
`endif
    win_vld = 1'b0;
    win_id  = '0;
    idx_sum = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NUM_REQ)) idx_sum = idx_sum - (IDW+1)'(NUM_REQ);
      cand = IDW'(idx_sum);
      if (req_m[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
    rr_adv = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and leaves the pointer untouched.
    if (bus.req[0]) begin
      win_vld = 1'b1;
      win_id  = '0;
      rr_adv  = rr_ptr;
    end
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    gnt_n   = '0;
    start_n = 1'b0;
    id_n    = id_q;
    dat_n   = dat_q;
    busy_n  = busy_q;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n = SEND;
          cnt_n   = CNT_W'(FRAME_CLKS - 1);
          gnt_n   = NUM_REQ'(1) << win_id;
          start_n = 1'b1;
          busy_n  = 1'b1;
          id_n    = win_id;
          dat_n   = bus.data_in[win_id*DATA_W +: DATA_W];
          rr_n    = rr_adv;
        end
      end
      SEND: begin
        if (cnt == '0) begin
          if (GAP_BITS != 0) begin
            state_n = GAP;
            cnt_n   = CNT_W'(GAP_CLKS - 1);
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      start_q <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rr_ptr  <= rr_n;
      gnt_q   <= gnt_n;
      id_q    <= id_n;
      start_q <= start_n;
      dat_q   <= dat_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.grant_id  = id_q;
  assign bus.tx_start  = start_q;
  assign bus.datain_tx = dat_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a
// cycle-level behavioural model (busy countdown + modulo round-robin search).
// Ports: none; instantiates uart_tx_arbiter_if and uart_tx_arbiter.
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int DW       = 7;
  localparam int CPB      = 521;
  localparam int BUSY_CYC = CPB * 10 + CPB * 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #50 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .CLKS_PER_BIT(CPB), .FRAME_BITS(10), .GAP_BITS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int busy_left   = 0;
  int rr          = 0;
  int gnt3_seen   = 0;
  bit auto_drop   = 1'b0;
  logic [N-1:0]  e_gnt   = '0;
  logic [1:0]    e_id    = '0;
  logic          e_start = 1'b0;
  logic [DW-1:0] e_dat   = '0;
  int            g_id[$];
  int            g_cyc[$];
  logic [DW-1:0] g_dat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    bus.data_in[i*DW +: DW] = w;
  endtask

  // Behavioural model of one rising edge, using the inputs that are stable at it.
  task automatic model_edge();
    int w;
    bit upd;
    logic [N-1:0] r;
    e_gnt   = '0;
    e_start = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else if (bus.req != '0) begin
      r   = bus.req;
      w   = -1;
      upd = 1'b1;
`ifdef UART_TX_ARB_PRIO0_EN
      if (r[0]) begin
        w   = 0;
        upd = 1'b0;
      end
      r[0] = 1'b0;
`endif
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(rr + k) % N]) w = (rr + k) % N;
      e_gnt     = N'(1) << w;
      e_start   = 1'b1;
      e_id      = 2'(w);
      e_dat     = bus.data_in[w*DW +: DW];
      busy_left = BUSY_CYC;
      if (upd) rr = (w + 1) % N;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("outputs", {bus.gnt, bus.grant_id, bus.tx_start, bus.datain_tx, bus.busy},
        {e_gnt, e_id, e_start, e_dat, (busy_left > 0)});
    if (bus.gnt != '0) begin
      g_id.push_back(int'(bus.grant_id));
      g_cyc.push_back(cyc);
      g_dat.push_back(bus.datain_tx);
    end
    if (bus.gnt[3]) gnt3_seen++;
    if (auto_drop) bus.req = bus.req & ~e_gnt;
  endtask

  task automatic wait_gnt(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.gnt == '0 && n < limit);
    chk({tag, "_gnt_seen"}, 64'(bus.gnt != '0), 64'd1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("reset_outputs", {bus.gnt, bus.grant_id, bus.tx_start, bus.datain_tx, bus.busy}, 64'd0);
    busy_left = 0;
    rr        = 0;
    e_gnt     = '0;
    e_id      = '0;
    e_start   = 1'b0;
    e_dat     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, t0, p;
    int exp_ids[5];
    logic [DW-1:0] w0, w1;
    logic [DW-1:0] words[4];

    bus.req     = '0;
    bus.data_in = '0;
    #5;

    // Single request from requester 2.
    do_reset();
    auto_drop = 1'b1;
    for (int i = 0; i < N; i++) set_word(i, 7'($urandom));
    set_word(2, 7'b101_1011);
    bus.req = 4'b0100;
    wait_gnt("single", 10);
    chk("single_gnt", bus.gnt, 4'b0100);
    chk("single_id", bus.grant_id, 2);
    chk("single_start", bus.tx_start, 1);
    chk("single_dat", bus.datain_tx, 7'h5B);
    n = 0;
    while (bus.busy && n < 7000) begin
      n++;
      step();
    end
    chk("single_busy_cycles", n, BUSY_CYC);

    // All four requesters held high.
    do_reset();
    auto_drop = 1'b0;
    words = '{7'h11, 7'h22, 7'h33, 7'h44};
    for (int i = 0; i < N; i++) set_word(i, words[i]);
    g_id.delete(); g_cyc.delete(); g_dat.delete();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) wait_gnt("rr", 6000);
`ifdef UART_TX_ARB_PRIO0_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    chk("rr_count", g_id.size(), 5);
    for (int g = 0; g < g_id.size() && g < 5; g++) begin
      chk("rr_id", g_id[g], exp_ids[g]);
      chk("rr_dat", g_dat[g], words[exp_ids[g]]);
      if (g > 0) chk("rr_spacing", g_cyc[g] - g_cyc[g-1], BUSY_CYC + 1);
    end
`ifdef UART_TX_ARB_PRIO0_EN
    g_id.delete(); g_cyc.delete(); g_dat.delete();
    bus.req = 4'b1110;
    for (int g = 0; g < 3; g++) wait_gnt("prio_rest", 6000);
    chk("prio_rest_count", g_id.size(), 3);
    for (int g = 0; g < g_id.size() && g < 3; g++) chk("prio_rest_id", g_id[g], g + 1);
`endif

    // Request during busy, withdrawal, and data stability after grant.
    do_reset();
    auto_drop = 1'b1;
    w0 = 7'($urandom);
    w1 = 7'($urandom);
    set_word(0, w0);
    set_word(1, w1);
    set_word(3, 7'($urandom));
    g_id.delete(); g_cyc.delete(); g_dat.delete();
    gnt3_seen = 0;
    bus.req = 4'b0001;
    wait_gnt("busy_first", 10);
    t0 = cyc;
    repeat (100) step();
    bus.req[1] = 1'b1;
    p = $urandom_range(500, 4000);
    repeat (p) step();
    bus.req[3] = 1'b1;
    repeat (50) step();
    bus.req[3] = 1'b0;
    set_word(0, w0 ^ 7'h7F);
    step();
    chk("hold_dat", bus.datain_tx, w0);
    wait_gnt("busy_second", 7000);
    chk("busy_second_id", bus.grant_id, 1);
    chk("busy_second_spacing", cyc - t0, BUSY_CYC + 1);
    chk("busy_second_dat", bus.datain_tx, w1);
    chk("withdraw_no_gnt3", gnt3_seen, 0);

    // Reset in the middle of SEND.
    do_reset();
    auto_drop = 1'b1;
    set_word(0, 7'($urandom));
    bus.req = 4'b0001;
    wait_gnt("midrst_first", 10);
    repeat (2000) step();
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 7'($urandom));
    bus.req = 4'b1010;
    wait_gnt("midrst_after", 10);
    chk("midrst_id", bus.grant_id, 1);
    chk("midrst_gnt", bus.gnt, 4'b0010);

    // Random request traffic with occasional withdrawals and data changes.
    do_reset();
    auto_drop = 1'b1;
    for (int c = 0; c < 12000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 1499) == 0) begin
          bus.req[i] = 1'b1;
          set_word(i, 7'($urandom));
        end else if (bus.req[i] && $urandom_range(0, 3999) == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 999) == 0) set_word(i, 7'($urandom));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
